pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  Consumes the execute-stage control-flow results: the taken/not-taken decision, the JALR target
//  (word address) and JAL/branch immediates. Owns the fetch PC and drives the imem request stream.
//  Flushes younger stages on every redirect. Sits between execute and fetch in the vanilla core.
//  Branches are statically predicted not-taken; JAL and JALR always redirect.
// PARAMETERS
//  imem_addr_width_p  "inv"  word-address width of instruction memory (PC register width)
//  pc_init_p          0      word address loaded on reset
// PORTS
//  clk_i             in   1     core clock
//  reset_i           in   1     synchronous, active-high reset
//  imem_v_o          out  1     fetch request valid
//  imem_addr_o       out  W     fetch word address (W = imem_addr_width_p)
//  imem_yumi_i       in   1     imem accepts request this cycle
//  stall_i           in   1     pipeline stall; no exe redirect is taken while high
//  exe_v_i           in   1     execute stage holds a valid instruction
//  exe_pc_i          in   W     word PC of execute instruction
//  exe_is_branch_i   in   1     instruction is a conditional branch
//  exe_is_jal_i      in   1     instruction is JAL
//  exe_is_jalr_i     in   1     instruction is JALR
//  exe_br_imm_i      in   13    sign-extended B-type byte offset
//  exe_jal_imm_i     in   21    sign-extended J-type byte offset
//  jump_now_i        in   1     branch condition true (from ALU)
//  jalr_addr_i       in   W     JALR word target (from ALU)
//  flush_o           out  1     kill fetch/decode contents this cycle
//  redirect_cnt_o    out  32    redirects taken (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: pc<=pc_init_p, state<=eRUN, pending cleared; imem_v_o=0, flush_o=0 in the reset cycle,
//    redirect_cnt_o=0. Reset mid-operation discards any held redirect.
//  - redirect = exe_v_i & ~stall_i & (exe_is_jal_i | exe_is_jalr_i | (exe_is_branch_i & jump_now_i)).
//  - Target: JALR -> jalr_addr_i; JAL -> exe_pc_i + exe_jal_imm_i[W+1:2];
//    branch -> exe_pc_i + exe_br_imm_i[W+1:2]. Immediates sign-extend to W; imm[1:0] ignored;
//    the sum wraps modulo 2^W. More than one is_* set -> undefined (assert in sim).
//  - flush_o is combinational: asserted in exactly the cycle the redirect is presented.
//  - States: eRUN, eHOLD.
//    eRUN: imem_v_o=1, imem_addr_o=pc. Redirect: imem_addr_o=target in that same cycle
//      (0-cycle redirect). If imem_yumi_i, then pc<=target+1 and stay in eRUN. Otherwise
//      held<=target and go to eHOLD. No redirect: pc<=pc+1 on imem_yumi_i, else hold.
//    eHOLD: imem_v_o=1, imem_addr_o=held. On imem_yumi_i, pc<=held+1 and go to eRUN.
//      A new redirect in eHOLD overwrites held (the younger exe result wins), asserts flush_o,
//      and presents the new target.
//  - imem_addr_o must not change while imem_v_o=1 and imem_yumi_i=0, except on a redirect.
//  - PC increment wraps from 2^W-1 to 0.
// CONFIGURATION
//  PC_REDIRECT_COUNT_EN defined: redirect_cnt_o increments by 1 per cycle with flush_o=1 and
//    saturates at 32'hFFFF_FFFF.
//  PC_REDIRECT_COUNT_EN undefined: no counter flops; redirect_cnt_o is tied to 0. The port is
//    always present.
// STRUCTURE
//  - Package pc_redirect_pkg: state enum {eRUN, eHOLD}; cause enum {eNONE, eBRANCH, eJAL, eJALR};
//    function word_offset(imm, W).
//  - Sub-module pc_redirect_target (combinational): cause + exe_pc + imms + jalr_addr -> target.
//  - Top: next-pc mux, pc/held/state flops, optional counter.
// TESTING
//  - Reset, pc_init_p=16, yumi always 1 -> imem_addr_o 16,17,18..., flush_o=0 throughout.
//  - BEQ taken at exe_pc=20 with imm=-8 -> addr 18 in the same cycle, flush_o=1, next addr 19.
//  - JALR with jalr_addr_i=0x40 while yumi=0 for 3 cycles -> eHOLD, addr held at 0x40,
//    then 0x41 after accept.
//  - Redirect with stall_i=1 -> no flush and no pc change; after release, redirect taken.
//  - Two redirects back-to-back in eHOLD (0x40 then 0x80) -> 0x80 issued; 0x40 never accepted.
//  - W=4, pc=15, JAL imm=+8 -> target (15+2)&15=1; with PC_REDIRECT_COUNT_EN,
//    count increments by 1 per redirect.

Source files
------------

// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg: shared types and the immediate-to-word-offset helper for the PC redirect unit.
package pc_redirect_pkg;
  typedef enum logic {eRUN, eHOLD} state_e;
  typedef enum logic [1:0] {eNONE, eBRANCH, eJAL, eJALR} cause_e;
  function automatic logic [31:0] word_offset(input logic [31:0] imm, input int w);
    logic [31:0] o;
    o = $unsigned($signed(imm) >>> 2);
    return (w >= 32) ? o : o & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: execute-result, imem request and flush signals of the PC redirect unit.
interface pc_redirect_unit_if #(parameter int imem_addr_width_p = 8);
  logic                         imem_v_o;
  logic [imem_addr_width_p-1:0] imem_addr_o;
  logic                         imem_yumi_i;
  logic                         stall_i;
  logic                         exe_v_i;
  logic [imem_addr_width_p-1:0] exe_pc_i;
  logic                         exe_is_branch_i;
  logic                         exe_is_jal_i;
  logic                         exe_is_jalr_i;
  logic [12:0]                  exe_br_imm_i;
  logic [20:0]                  exe_jal_imm_i;
  logic                         jump_now_i;
  logic [imem_addr_width_p-1:0] jalr_addr_i;
  logic                         flush_o;
  logic [31:0]                  redirect_cnt_o;
  modport slave (
    output imem_v_o, imem_addr_o, flush_o, redirect_cnt_o,
    input  imem_yumi_i, stall_i, exe_v_i, exe_pc_i, exe_is_branch_i, exe_is_jal_i,
           exe_is_jalr_i, exe_br_imm_i, exe_jal_imm_i, jump_now_i, jalr_addr_i
  );
  modport master (
    input  imem_v_o, imem_addr_o, flush_o, redirect_cnt_o,
    output imem_yumi_i, stall_i, exe_v_i, exe_pc_i, exe_is_branch_i, exe_is_jal_i,
           exe_is_jalr_i, exe_br_imm_i, exe_jal_imm_i, jump_now_i, jalr_addr_i
  );
endinterface

// File: rtl/pc_redirect_target.sv
// pc_redirect_target: combinational redirect target (JALR address or PC-relative word offset, wraps mod 2^W).
module pc_redirect_target
  import pc_redirect_pkg::*;
#(
  parameter int imem_addr_width_p = 8
) (
  input  cause_e                       cause,
  input  logic [imem_addr_width_p-1:0] exe_pc,
  input  logic [12:0]                  br_imm,
  input  logic [20:0]                  jal_imm,
  input  logic [imem_addr_width_p-1:0] jalr_addr,
  output logic [imem_addr_width_p-1:0] target
);
  logic [imem_addr_width_p-1:0] off;
  always_comb begin
    off = (cause == eJAL) ? imem_addr_width_p'(word_offset(32'(signed'(jal_imm)), imem_addr_width_p))
                          : imem_addr_width_p'(word_offset(32'(signed'(br_imm)), imem_addr_width_p));
    target = (cause == eJALR) ? jalr_addr : exe_pc + off;
  end
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC owner with 0-cycle redirect and flush; PC_REDIRECT_COUNT_EN enables the redirect counter.
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter int imem_addr_width_p = 8,
  parameter int pc_init_p         = 0
) (
  input logic clk_i,
  input logic reset_i,
  pc_redirect_unit_if.slave bus
);
  localparam int W = imem_addr_width_p;
  state_e         state;
  cause_e         cause;
  logic           redirect;
  logic [W-1:0]   pc, held, target;
  pc_redirect_target #(.imem_addr_width_p(W)) u_target (
    .cause     (cause),
    .exe_pc    (bus.exe_pc_i),
    .br_imm    (bus.exe_br_imm_i),
    .jal_imm   (bus.exe_jal_imm_i),
    .jalr_addr (bus.jalr_addr_i),
    .target    (target)
  );
  always_comb begin
    cause = bus.exe_is_jalr_i ? eJALR :
            bus.exe_is_jal_i  ? eJAL  :
            (bus.exe_is_branch_i & bus.jump_now_i) ? eBRANCH : eNONE;
    redirect = ~reset_i & bus.exe_v_i & ~bus.stall_i & (cause != eNONE);
    bus.flush_o = redirect;
    bus.imem_v_o = ~reset_i;
    bus.imem_addr_o = redirect ? target : (state == eHOLD) ? held : pc;
  end
  // An unaccepted redirect parks its target in held until imem takes it or a younger redirect replaces it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc    <= W'(pc_init_p);
      held  <= '0;
      state <= eRUN;
    end else if (redirect) begin
      if (bus.imem_yumi_i) begin
        pc    <= target + W'(1);
        state <= eRUN;
      end else begin
        held  <= target;
        state <= eHOLD;
      end
    end else if (state == eHOLD) begin
      if (bus.imem_yumi_i) begin
        pc    <= held + W'(1);
        state <= eRUN;
      end
    end else if (bus.imem_yumi_i) begin
      pc <= pc + W'(1);
    end
  end
`ifdef PC_REDIRECT_COUNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt <= '0;
    else if (bus.flush_o && cnt != '1) cnt <= cnt + 32'd1;
  end
  assign bus.redirect_cnt_o = cnt;
`else
  assign bus.redirect_cnt_o = 32'd0;
`endif
  a_one_kind: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.exe_v_i |-> $onehot0({bus.exe_is_branch_i, bus.exe_is_jal_i, bus.exe_is_jalr_i}));
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and randomized checks of pc_redirect_unit against an address-stream model.
module tb_pc_redirect_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int m_next = 16;
  int unsigned m_cnt = 0;
`ifdef PC_REDIRECT_COUNT_EN
  localparam bit cnt_en = 1'b1;
`else
  localparam bit cnt_en = 1'b0;
`endif
  pc_redirect_unit_if #(.imem_addr_width_p(8)) b ();
  pc_redirect_unit_if #(.imem_addr_width_p(4)) s ();
  pc_redirect_unit #(.imem_addr_width_p(8), .pc_init_p(16)) dut (.clk_i(clk), .reset_i(rst), .bus(b));
  pc_redirect_unit #(.imem_addr_width_p(4), .pc_init_p(0)) dut_s (.clk_i(clk), .reset_i(rst), .bus(s));
  always #5 clk = ~clk;
  // The model tracks only the address that will be offered next absent a redirect.
  function automatic int m_target();
    int off;
    off = b.exe_is_jal_i ? (int'($signed(b.exe_jal_imm_i)) >>> 2) : (int'($signed(b.exe_br_imm_i)) >>> 2);
    return b.exe_is_jalr_i ? int'(b.jalr_addr_i) : (int'(b.exe_pc_i) + off) & 255;
  endfunction
  function automatic bit m_redirect();
    return !rst && b.exe_v_i && !b.stall_i && (b.exe_is_jal_i || b.exe_is_jalr_i || (b.exe_is_branch_i && b.jump_now_i));
  endfunction
  function automatic int m_addr();
    return m_redirect() ? m_target() : m_next;
  endfunction
  task automatic tick();
    if (rst) begin
      m_next = 16;
      m_cnt = 0;
    end else begin
      if (m_redirect()) m_cnt++;
      m_next = b.imem_yumi_i ? (m_addr() + 1) & 255 : m_addr();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    b.exe_v_i = 0; b.exe_is_branch_i = 0; b.exe_is_jal_i = 0; b.exe_is_jalr_i = 0;
    b.jump_now_i = 0; b.stall_i = 0;
  endtask
  task automatic idle_s();
    s.exe_v_i = 0; s.exe_is_branch_i = 0; s.exe_is_jal_i = 0; s.exe_is_jalr_i = 0;
    s.jump_now_i = 0; s.stall_i = 0;
  endtask
  task automatic jalr(input logic [7:0] a);
    idle(); b.exe_v_i = 1; b.exe_is_jalr_i = 1; b.jalr_addr_i = a;
  endtask
  task automatic test_reset();
    rst = 1; idle(); b.exe_v_i = 1; b.exe_is_jal_i = 1; b.imem_yumi_i = 1;
    @(negedge clk);
    checks++; if (b.imem_v_o !== 1'b0) begin failures++; $display("FAIL reset_v got=%0b exp=0", b.imem_v_o); end
    checks++; if (b.flush_o !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", b.flush_o); end
    checks++; if (b.redirect_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", b.redirect_cnt_o); end
    checks++; if (s.imem_v_o !== 1'b0) begin failures++; $display("FAIL reset_v_small got=%0b exp=0", s.imem_v_o); end
    tick();
    rst = 0; idle();
  endtask
  task automatic test_sequential();
    b.imem_yumi_i = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (b.imem_addr_o !== 8'(16 + i)) begin failures++; $display("FAIL seq_addr got=%0h exp=%0h", b.imem_addr_o, 8'(16 + i)); end
      checks++; if (b.imem_v_o !== 1'b1 || b.flush_o !== 1'b0) begin failures++; $display("FAIL seq_ctl got v=%0b f=%0b exp v=1 f=0", b.imem_v_o, b.flush_o); end
      tick();
    end
  endtask
  task automatic test_branch();
    b.imem_yumi_i = 1;
    b.exe_v_i = 1; b.exe_is_branch_i = 1; b.jump_now_i = 1; b.exe_pc_i = 8'd20; b.exe_br_imm_i = 13'h1FF8;
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'd18) begin failures++; $display("FAIL br_addr got=%0h exp=12", b.imem_addr_o); end
    checks++; if (b.flush_o !== 1'b1) begin failures++; $display("FAIL br_flush got=%0b exp=1", b.flush_o); end
    tick(); idle();
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'd19 || b.flush_o !== 1'b0) begin failures++; $display("FAIL br_next got=%0h f=%0b exp=13 f=0", b.imem_addr_o, b.flush_o); end
    tick();
    b.exe_v_i = 1; b.exe_is_branch_i = 1; b.jump_now_i = 0;
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'd20 || b.flush_o !== 1'b0) begin failures++; $display("FAIL br_not_taken got=%0h f=%0b exp=14 f=0", b.imem_addr_o, b.flush_o); end
    tick(); idle();
  endtask
  task automatic test_jalr_hold();
    b.imem_yumi_i = 0; jalr(8'h40);
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'h40 || b.flush_o !== 1'b1) begin failures++; $display("FAIL jalr_addr got=%0h f=%0b exp=40 f=1", b.imem_addr_o, b.flush_o); end
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (b.imem_addr_o !== 8'h40 || b.flush_o !== 1'b0) begin failures++; $display("FAIL jalr_hold got=%0h f=%0b exp=40 f=0", b.imem_addr_o, b.flush_o); end
      tick();
    end
    b.imem_yumi_i = 1;
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'h40) begin failures++; $display("FAIL jalr_accept got=%0h exp=40", b.imem_addr_o); end
    tick();
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'h41) begin failures++; $display("FAIL jalr_after got=%0h exp=41", b.imem_addr_o); end
    tick();
  endtask
  task automatic test_stall();
    b.imem_yumi_i = 0;
    b.exe_v_i = 1; b.exe_is_branch_i = 1; b.jump_now_i = 1; b.exe_pc_i = 8'h30; b.exe_br_imm_i = 13'd16; b.stall_i = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (b.flush_o !== 1'b0 || b.imem_addr_o !== 8'h42) begin failures++; $display("FAIL stall got=%0h f=%0b exp=42 f=0", b.imem_addr_o, b.flush_o); end
      tick();
    end
    b.stall_i = 0; b.imem_yumi_i = 1;
    @(negedge clk);
    checks++; if (b.flush_o !== 1'b1 || b.imem_addr_o !== 8'h34) begin failures++; $display("FAIL stall_release got=%0h f=%0b exp=34 f=1", b.imem_addr_o, b.flush_o); end
    tick(); idle();
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'h35) begin failures++; $display("FAIL stall_next got=%0h exp=35", b.imem_addr_o); end
    tick();
  endtask
  task automatic test_back_to_back();
    b.imem_yumi_i = 0; jalr(8'h40);
    @(negedge clk);
    checks++; if (b.flush_o !== 1'b1) begin failures++; $display("FAIL b2b_first got f=%0b exp=1", b.flush_o); end
    tick(); jalr(8'h80);
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'h80 || b.flush_o !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0h f=%0b exp=80 f=1", b.imem_addr_o, b.flush_o); end
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (b.imem_addr_o !== 8'h80) begin failures++; $display("FAIL b2b_hold got=%0h exp=80", b.imem_addr_o); end
      tick();
    end
    b.imem_yumi_i = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'h81) begin failures++; $display("FAIL b2b_after got=%0h exp=81", b.imem_addr_o); end
    tick();
  endtask
  task automatic test_reset_mid();
    b.imem_yumi_i = 0; jalr(8'h55);
    @(negedge clk);
    tick(); idle(); rst = 1;
    @(negedge clk);
    checks++; if (b.imem_v_o !== 1'b0) begin failures++; $display("FAIL rmid_v got=%0b exp=0", b.imem_v_o); end
    tick(); rst = 0;
    @(negedge clk);
    checks++; if (b.imem_addr_o !== 8'd16 || b.imem_v_o !== 1'b1) begin failures++; $display("FAIL rmid_addr got=%0h v=%0b exp=10 v=1", b.imem_addr_o, b.imem_v_o); end
    tick();
  endtask
  task automatic test_random();
    logic [7:0] prev_addr = '0;
    bit prev_stuck = 0;
    for (int n = 0; n < 400; n++) begin
      int kind;
      idle();
      rst = ($urandom_range(0, 49) == 0);
      kind = $urandom_range(0, 3);
      b.exe_v_i = $urandom_range(0, 1) == 1;
      b.exe_is_branch_i = (kind == 1); b.exe_is_jal_i = (kind == 2); b.exe_is_jalr_i = (kind == 3);
      b.jump_now_i = 1'($urandom); b.stall_i = ($urandom_range(0, 3) == 0);
      b.imem_yumi_i = 1'($urandom); b.exe_pc_i = 8'($urandom); b.jalr_addr_i = 8'($urandom);
      b.exe_br_imm_i = 13'($urandom); b.exe_jal_imm_i = 21'($urandom);
      @(negedge clk);
      checks++; if (b.imem_v_o !== !rst) begin failures++; $display("FAIL rnd_v got=%0b exp=%0b", b.imem_v_o, !rst); end
      checks++; if (b.flush_o !== m_redirect()) begin failures++; $display("FAIL rnd_flush got=%0b exp=%0b", b.flush_o, m_redirect()); end
      checks++; if (b.redirect_cnt_o !== (cnt_en ? m_cnt : 32'd0)) begin failures++; $display("FAIL rnd_cnt got=%0d exp=%0d", b.redirect_cnt_o, cnt_en ? m_cnt : 32'd0); end
      if (!rst) begin
        checks++; if (b.imem_addr_o !== 8'(m_addr())) begin failures++; $display("FAIL rnd_addr got=%0h exp=%0h", b.imem_addr_o, 8'(m_addr())); end
        if (prev_stuck && !m_redirect()) begin
          checks++; if (b.imem_addr_o !== prev_addr) begin failures++; $display("FAIL rnd_stable got=%0h exp=%0h", b.imem_addr_o, prev_addr); end
        end
      end
      prev_stuck = !rst && !b.imem_yumi_i;
      prev_addr = 8'(m_addr());
      tick();
    end
    rst = 0; idle();
  endtask
  task automatic test_wrap();
    rst = 1; idle(); idle_s(); s.imem_yumi_i = 1;
    @(negedge clk);
    tick(); rst = 0;
    s.exe_v_i = 1; s.exe_is_jalr_i = 1; s.jalr_addr_i = 4'd15;
    @(negedge clk);
    checks++; if (s.imem_addr_o !== 4'd15 || s.flush_o !== 1'b1) begin failures++; $display("FAIL w_jalr got=%0h f=%0b exp=f f=1", s.imem_addr_o, s.flush_o); end
    tick(); idle_s();
    @(negedge clk);
    checks++; if (s.imem_addr_o !== 4'd0) begin failures++; $display("FAIL w_incwrap got=%0h exp=0", s.imem_addr_o); end
    tick();
    s.exe_v_i = 1; s.exe_is_jal_i = 1; s.exe_pc_i = 4'd15; s.exe_jal_imm_i = 21'd8;
    @(negedge clk);
    checks++; if (s.imem_addr_o !== 4'd1 || s.flush_o !== 1'b1) begin failures++; $display("FAIL w_jal got=%0h f=%0b exp=1 f=1", s.imem_addr_o, s.flush_o); end
    tick(); idle_s();
    @(negedge clk);
    checks++; if (s.imem_addr_o !== 4'd2) begin failures++; $display("FAIL w_jal_next got=%0h exp=2", s.imem_addr_o); end
    tick();
    s.exe_v_i = 1; s.exe_is_branch_i = 1; s.jump_now_i = 1; s.exe_pc_i = 4'd1; s.exe_br_imm_i = 13'h1FF8;
    @(negedge clk);
    checks++; if (s.imem_addr_o !== 4'd15) begin failures++; $display("FAIL w_br got=%0h exp=f", s.imem_addr_o); end
    tick(); idle_s();
    @(negedge clk);
    checks++; if (s.redirect_cnt_o !== (cnt_en ? 32'd3 : 32'd0)) begin failures++; $display("FAIL w_cnt got=%0d exp=%0d", s.redirect_cnt_o, cnt_en ? 3 : 0); end
    tick();
  endtask
  initial begin
    idle(); idle_s();
    b.imem_yumi_i = 0; b.exe_pc_i = '0; b.exe_br_imm_i = '0; b.exe_jal_imm_i = '0; b.jalr_addr_i = '0;
    s.imem_yumi_i = 0; s.exe_pc_i = '0; s.exe_br_imm_i = '0; s.exe_jal_imm_i = '0; s.jalr_addr_i = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr_hold();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
